// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the snooping cache bus arbiter: FSM state type and the
// cache bus packet width macro (defined only if the cache headers have not already).
`ifndef CACHE_BUS_PKT_WIDTH
`define CACHE_BUS_PKT_WIDTH(dw) (8 + 16*(dw))
`endif

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } bus_arb_state_e;

    localparam int unsigned GRANT_CNT_W = 32;

endpackage

// File: rtl/bus_arbiter_if.sv
// Cache-side request/accept signals and bus-engine handshake of the bus arbiter.
// The master modport is the arbiter's view; slave is the caches/engine view.
interface bus_arbiter_if #(
    parameter int num_caches_p     = 2,
    parameter int dma_data_width_p = 1
);
    localparam int pkt_w_lp = `CACHE_BUS_PKT_WIDTH(dma_data_width_p);
    localparam int id_w_lp  = $clog2(num_caches_p);

    logic [num_caches_p-1:0]               cb_valid_i;
    logic [num_caches_p-1:0][pkt_w_lp-1:0] cb_pkt_i;
    logic [num_caches_p-1:0]               cb_yumi_o;
    logic                                  bus_valid_o;
    logic                                  bus_ready_i;
    logic [pkt_w_lp-1:0]                   bus_pkt_o;
    logic [id_w_lp-1:0]                    bus_id_o;
    logic                                  bus_done_i;
    logic                                  busy_o;

    modport master (
        input  cb_valid_i, cb_pkt_i, bus_ready_i, bus_done_i,
        output cb_yumi_o, bus_valid_o, bus_pkt_o, bus_id_o, busy_o
    );

    modport slave (
        output cb_valid_i, cb_pkt_i, bus_ready_i, bus_done_i,
        input  cb_yumi_o, bus_valid_o, bus_pkt_o, bus_id_o, busy_o
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping
// from n_p-1 back to 0.
module rr_pick #(
    parameter  int n_p     = 2,
    localparam int id_w_lp = $clog2(n_p)
) (
    input  logic [n_p-1:0]     req_i,
    input  logic [id_w_lp-1:0] ptr_i,
    output logic [n_p-1:0]     gnt_o,
    output logic [id_w_lp-1:0] gnt_id_o,
    output logic               any_o
);

    logic [id_w_lp:0]   sum;
    logic [id_w_lp-1:0] idx;
    logic               found;

    // One spare bit in sum lets ptr+k be folded back below n_p without modulo.
    always_comb begin
        gnt_o    = '0;
        gnt_id_o = '0;
        any_o    = |req_i;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < n_p; k++) begin
            sum = {1'b0, ptr_i} + (id_w_lp+1)'(k);
            if (sum >= (id_w_lp+1)'(n_p)) begin
                sum = sum - (id_w_lp+1)'(n_p);
            end
            idx = sum[id_w_lp-1:0];
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_id_o   = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared snooping cache bus; one coherence transaction in flight.
// Define BUS_ARB_PERF_EN to add saturating per-cache grant counters (grant_cnt_o).
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter  int num_caches_p     = 2,
    parameter  int dma_data_width_p = 1,
    localparam int pkt_w_lp         = `CACHE_BUS_PKT_WIDTH(dma_data_width_p),
    localparam int id_w_lp          = $clog2(num_caches_p)
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    bus_arbiter_if.master bus_if
`ifdef BUS_ARB_PERF_EN
    ,
    output logic [num_caches_p-1:0][GRANT_CNT_W-1:0] grant_cnt_o
`endif
);

    bus_arb_state_e          state_q, state_d;
    logic [pkt_w_lp-1:0]     pkt_q, pkt_d;
    logic [id_w_lp-1:0]      id_q, id_d;
    logic [id_w_lp-1:0]      rr_ptr_q, rr_ptr_d;
    logic [num_caches_p-1:0] gnt;
    logic [id_w_lp-1:0]      gnt_id;
    logic                    any_req;
    logic [num_caches_p-1:0] yumi;
    logic                    bus_valid;

    rr_pick #(.n_p(num_caches_p)) u_rr_pick (
        .req_i    (bus_if.cb_valid_i),
        .ptr_i    (rr_ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .any_o    (any_req)
    );

    function automatic logic [id_w_lp-1:0] next_ptr(input logic [id_w_lp-1:0] id);
        return (id == id_w_lp'(num_caches_p - 1)) ? '0 : id + id_w_lp'(1);
    endfunction

    // Yumi is gated by reset so a cache still holding valid never sees an accept while held in reset.
    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        id_d      = id_q;
        rr_ptr_d  = rr_ptr_q;
        yumi      = '0;
        bus_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && nreset_i) begin
                    yumi    = gnt;
                    pkt_d   = bus_if.cb_pkt_i[gnt_id];
                    id_d    = gnt_id;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus_valid = 1'b1;
                if (bus_if.bus_ready_i) begin
                    if (bus_if.bus_done_i) begin
                        rr_ptr_d = next_ptr(id_q);
                        state_d  = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (bus_if.bus_done_i) begin
                    rr_ptr_d = next_ptr(id_q);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus_if.cb_yumi_o   = yumi;
    assign bus_if.bus_valid_o = bus_valid;
    assign bus_if.bus_pkt_o   = pkt_q;
    assign bus_if.bus_id_o    = id_q;
    assign bus_if.busy_o      = (state_q != IDLE);

`ifdef BUS_ARB_PERF_EN
    logic [num_caches_p-1:0][GRANT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < num_caches_p; i++) begin
            if (yumi[i] && (cnt_q[i] != {GRANT_CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + GRANT_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule
